clk_div_bank: RTL

Parametrised multi-channel clock divider that replaces the single fixed divide-by-4 `core_clk` toggle in `top`. It generates `CHANNELS` independent divided clocks from `clk`, each with a runtime-programmable ratio, a per-channel run enable and a one-cycle `tick` strobe. Ratio changes and stops take effect only at period boundaries, so no output ever produces a runt pulse. A global `sync` input realigns all running channels. The block sits at the top level, next to clock/reset entry, and feeds the core and peripheral clock/enable inputs.

---
 rtl/clk_div_bank.sv | 130 +++++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent, runtime-programmable clock dividers.
// Ratio changes and stops land on period boundaries, so outputs never emit runt pulses.
module clk_div_bank #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned RESET_DIV = 1,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] div_clk,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] pending
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(RESET_DIV);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

    // Writes aimed past the last channel are dropped here, before any channel sees them.
    logic cfg_valid;
    assign cfg_valid = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_cur_q, div_cur_d;
        logic [DIV_W-1:0] div_nxt_q, div_nxt_d;
        logic             div_clk_q, div_clk_d;
        logic             tick_q, tick_d;
        logic             pending_q, pending_d;
        logic             apply_nxt;
        logic             cfg_hit;

        assign cfg_hit = cfg_valid && (cfg_ch == CH_W'(i));

        // NOTE: every signal written here gets a default first, so no path leaves a latch.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            div_clk_d = div_clk_q;
            tick_d    = 1'b0;
            div_cur_d = div_cur_q;
            div_nxt_d = div_nxt_q;
            pending_d = pending_q;
            apply_nxt = 1'b0;

            unique case (state_q)
                IDLE: begin
                    cnt_d     = '0;
                    div_clk_d = 1'b0;
                    if (en[i]) begin
                        state_d   = RUN;
                        apply_nxt = pending_q;
                    end
                end
                RUN: begin
                    if (!div_clk_q && !en[i]) begin
                        // Stopping in the low phase is immediate; the low phase is never stretched.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == div_cur_q) begin
                        div_clk_d = !div_clk_q;
                        cnt_d     = '0;
                        tick_d    = !div_clk_q;
                        if (div_clk_q) begin
                            apply_nxt = pending_q;
                            if (!en[i]) begin
                                state_d = IDLE;
                            end
                        end
                    end else if (sync && !div_clk_q) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (apply_nxt) begin
                div_cur_d = div_nxt_q;
                pending_d = 1'b0;
            end
            // A write on a boundary cycle re-arms pending after the old value is consumed.
            if (cfg_hit) begin
                div_nxt_d = cfg_div;
                pending_d = 1'b1;
            end
        end

        // NOTE: state registers use non-blocking assignments so all channels update together.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                // NOTE: divisors reset to RESET_DIV, not zero, so a freshly reset bank runs the legacy ratio.
                state_q   <= IDLE;
                cnt_q     <= '0;
                div_cur_q <= RST_DIV;
                div_nxt_q <= RST_DIV;
                div_clk_q <= 1'b0;
                tick_q    <= 1'b0;
                pending_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                div_cur_q <= div_cur_d;
                div_nxt_q <= div_nxt_d;
                div_clk_q <= div_clk_d;
                tick_q    <= tick_d;
                pending_q <= pending_d;
            end
        end

        assign div_clk[i] = div_clk_q;
        assign tick[i]    = tick_q;
        assign running[i] = (state_q == RUN);
        assign pending[i] = pending_q;
    end

endmodule
